// File: rtl/life_pkg.sv
// Shared types and defaults for the LED board scanner: FSM state encoding,
// default geometry/timing, and a width helper used by every scanner file.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam int N_DEFAULT     = 8;
  localparam int DWELL_DEFAULT = 4;
  localparam int BLANK_DEFAULT = 1;

  // Bits needed to hold 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/board_scanner_if.sv
// Board scanner bus: frame request and live board in, row/column drive and status out.
// master = board owner (drives ena/cells), slave = scanner.
interface board_scanner_if
  import life_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic           ena;
  logic [N*N-1:0] cells;
  logic [N-1:0]   rows;
  logic [N-1:0]   cols;
  logic           busy;
  logic           frame_done;

  modport master (
    output ena, cells,
    input  rows, cols, busy, frame_done
  );

  modport slave (
    input  ena, cells,
    output rows, cols, busy, frame_done
  );

endinterface

// File: rtl/board_scanner_row_decoder.sv
// Binary row index to one-hot row drive, forced to all-zero when not enabled.
// Purely combinational; the scanner registers the result.
module row_decoder
  import life_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int RW = clog2_min1(N_DEFAULT)
) (
  input  logic [RW-1:0] row,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (row == RW'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_scanner.sv
// Multiplexed N x N LED scanner: snapshots the board, drives each row for DWELL cycles
// then BLANK dark cycles; all outputs registered, first row visible one cycle after start.
module board_scanner
  import life_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DWELL = DWELL_DEFAULT,
  parameter int BLANK = BLANK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  board_scanner_if.slave  bus
);

  localparam int RW   = clog2_min1(N);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = clog2_min1(CMAX);

  state_e         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*N-1:0] snap_q, snap_d;
  logic [N-1:0]   rows_q, rows_d;
  logic [N-1:0]   cols_q, cols_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic           scan_d;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ena) begin
          snap_d  = bus.cells;
          row_d   = '0;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_BLANK: begin
        if (cnt_q == CW'(BLANK - 1)) begin
          cnt_d = '0;
          if (row_q == RW'(N - 1)) begin
            // Last row done: ena here chains straight into the next frame.
            frame_done_d = 1'b1;
            row_d        = '0;
            if (bus.ena) begin
              snap_d  = bus.cells;
              state_d = ST_SCAN;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            row_d   = row_q + RW'(1);
            state_d = ST_SCAN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next state so they line up with the state they describe.
  assign scan_d = (state_d == ST_SCAN);
  assign busy_d = (state_d != ST_IDLE);

  row_decoder #(
    .N  (N),
    .RW (RW)
  ) u_row_decoder (
    .row    (row_d),
    .en     (scan_d),
    .onehot (rows_d)
  );

  always_comb begin
    cols_d = '0;
    if (scan_d) begin
      cols_d = N'(snap_d >> (int'(row_d) * N));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.rows       = rows_q;
  assign bus.cols       = cols_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_board_scanner.sv
// Board scanner bench: frame-position reference model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_board_scanner;
  import life_pkg::*;

  localparam int N  = 8;
  localparam int DW = 4;
  localparam int BL = 1;
  localparam int P  = DW + BL;
  localparam int L  = N * P;
  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;

  logic clk = 1'b0;
  logic rst = 1'b1;

  board_scanner_if #(.N(N)) bus ();

  board_scanner #(
    .N     (N),
    .DWELL (DW),
    .BLANK (BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a position 0..L-1; row and phase follow by division.
  bit          m_active = 1'b0;
  int          m_p      = 0;
  logic [63:0] m_snap   = '0;
  bit          m_done   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_p      = 0;
      m_snap   = '0;
      m_done   = 1'b0;
    end else if (!m_active) begin
      m_done = 1'b0;
      if (bus.ena) begin
        m_active = 1'b1;
        m_p      = 0;
        m_snap   = bus.cells;
      end
    end else if (m_p == L - 1) begin
      m_done = 1'b1;
      if (bus.ena) begin
        m_p    = 0;
        m_snap = bus.cells;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_p++;
      m_done = 1'b0;
    end
  end

  bit chk_en    = 1'b0;
  bit prev_done = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] e_rows;
    logic [N-1:0] e_cols;
    if (chk_en) begin
      e_rows = '0;
      e_cols = '0;
      if (m_active && ((m_p % P) < DW)) begin
        e_rows[m_p / P] = 1'b1;
        e_cols = N'(m_snap >> ((m_p / P) * N));
      end
      check("model_rows", bus.rows, e_rows);
      check("model_cols", bus.cols, e_cols);
      check("model_busy", bus.busy, m_active);
      check("model_frame_done", bus.frame_done, m_done);
      check("rows_onehot0", $onehot0(bus.rows), 1'b1);
      check("frame_done_not_twice", prev_done && bus.frame_done, 1'b0);
      prev_done = bus.frame_done;
    end
  end

  initial begin
    int found;
    int nd;
    int done_at[3];
    int idle_cnt;

    bus.ena   = 1'b0;
    bus.cells = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rows", bus.rows, 0);
    check("reset_cols", bus.cols, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.frame_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single glider frame, board overwritten mid-frame.
    bus.cells = GLIDER;
    bus.ena   = 1'b1;
    @(negedge clk);
    bus.ena = 1'b0;
    found   = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == 0) begin
        check("t1_rows_c0", bus.rows, 8'h01);
        check("t1_cols_c0", bus.cols, 8'h02);
        check("t1_busy_c0", bus.busy, 1);
      end
      if (cyc == 4) check("t1_rows_blank_c4", bus.rows, 8'h00);
      if (cyc == 5) begin
        check("t1_rows_c5", bus.rows, 8'h02);
        check("t1_cols_c5", bus.cols, 8'h04);
      end
      if (cyc == 10) bus.cells = '1;
      if (cyc == 12) begin
        check("t1_rows_c12", bus.rows, 8'h04);
        check("t1_cols_c12_isolated", bus.cols, 8'h07);
      end
      if (cyc == 35) begin
        check("t1_rows_c35", bus.rows, 8'h80);
        check("t1_cols_c35", bus.cols, 8'h00);
      end
      if (bus.frame_done) begin
        found = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t1_done_cycle", found, 40);
    @(negedge clk);
    check("t1_idle_busy", bus.busy, 0);
    check("t1_idle_rows", bus.rows, 0);

    // Continuous run: three frames back to back, random board every cycle.
    nd       = 0;
    idle_cnt = 0;
    bus.ena  = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 200; cyc++) begin
      bus.cells = {$urandom, $urandom};
      if (cyc == 100) bus.ena = 1'b0;
      if (cyc < 120 && !bus.busy) idle_cnt++;
      if (bus.frame_done && nd < 3) begin
        done_at[nd] = cyc;
        nd++;
      end
      if (cyc >= 121) break;
      @(negedge clk);
    end
    check("t2_done_count", nd, 3);
    check("t2_done0", done_at[0], 40);
    check("t2_done1", done_at[1], 80);
    check("t2_done2", done_at[2], 120);
    check("t2_no_idle_gap", idle_cnt, 0);
    check("t2_idle_after", bus.busy, 0);

    // ena held for a few cycles then dropped mid-frame.
    bus.ena = 1'b1;
    @(negedge clk);
    found = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == 5) bus.ena = 1'b0;
      if (bus.frame_done) begin
        found = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t3_done_cycle", found, 40);
    @(negedge clk);
    check("t3_idle_rows", bus.rows, 0);
    check("t3_idle_busy", bus.busy, 0);

    // Reset in the middle of a frame, then a clean restart.
    bus.cells = GLIDER;
    bus.ena   = 1'b1;
    @(negedge clk);
    bus.ena = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_rows", bus.rows, 0);
    check("t4_rst_cols", bus.cols, 0);
    check("t4_rst_busy", bus.busy, 0);
    check("t4_rst_done", bus.frame_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.cells = 64'h0000_0000_0000_00A5;
    bus.ena   = 1'b1;
    @(negedge clk);
    bus.ena = 1'b0;
    check("t4_restart_rows", bus.rows, 8'h01);
    check("t4_restart_cols", bus.cols, 8'hA5);
    repeat (45) @(negedge clk);

    // Random traffic including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bus.ena   = ($urandom_range(0, 99) < 30);
      bus.cells = {$urandom, $urandom};
      rst       = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst     = 1'b0;
    bus.ena = 1'b0;
    repeat (50) @(negedge clk);
    check("t5_final_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
